// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter: stall bus encodings,
// arbiter state encoding and the access-counter helper.
package mem_arbiter_pkg;

    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;
    localparam logic RstEnable = 1'b0;

    // [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] wb
    typedef logic [5:0] stall_bus_t;

    localparam stall_bus_t StallFreeze  = {NoStop, Stop, Stop, Stop, Stop, Stop};
    localparam stall_bus_t StallLoadUse = {NoStop, NoStop, NoStop, Stop, Stop, Stop};
    localparam stall_bus_t StallNone    = {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};

    typedef enum logic {
        StIf  = 1'b0,
        StMem = 1'b1
    } state_e;

    // Wide enough for ACC_CYCLES up to 8.
    localparam int unsigned CntW = 3;

    function automatic logic acc_last(input logic [CntW-1:0] cnt, input int unsigned acc);
        return cnt == CntW'(acc - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single SRAM between instruction fetch and MEM-stage load/store.
// Each slot is an optional MEM access followed by one fetch; the pipeline is frozen until slot end.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ACC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ex_memreq_i,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              stallreq_id_i,
    output logic [5:0]        stall_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o
);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic last;
    logic mem_store;
    logic mem_load;

    assign last      = acc_last(cnt_q, ACC_CYCLES);
    assign mem_store = mem_req_i & mem_we_i;
    assign mem_load  = mem_req_i & ~mem_we_i;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q     <= StIf;
            cnt_q       <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        cnt_d       = last ? '0 : cnt_q + CntW'(1);
        state_d     = state_q;
        mem_rdata_d = mem_rdata_q;
        unique case (state_q)
            StIf: begin
                // MEM entry is decided only here; mem_req_i is not consulted.
                if (last && ex_memreq_i) begin
                    state_d = StMem;
                end
            end
            StMem: begin
                if (last) begin
                    state_d = StIf;
                    if (mem_load) begin
                        mem_rdata_d = ram_rdata_i;
                    end
                end
            end
            default: state_d = StIf;
        endcase
    end

    // Outputs are forced idle while reset is asserted so an in-flight write aborts at once.
    always_comb begin
        stall_o     = StallFreeze;
        inst_o      = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_ce_n_o  = 1'b1;
        ram_oe_n_o  = 1'b1;
        ram_we_n_o  = 1'b1;
        if (rst != RstEnable) begin
            unique case (state_q)
                StIf: begin
                    ram_addr_o = pc_i;
                    ram_ce_n_o = 1'b0;
                    ram_oe_n_o = 1'b0;
                    if (last) begin
                        inst_o  = ram_rdata_i;
                        stall_o = stallreq_id_i ? StallLoadUse : StallNone;
                    end
                end
                StMem: begin
                    ram_addr_o = mem_addr_i;
                    ram_ce_n_o = 1'b0;
                    if (mem_store) begin
                        ram_wdata_o = mem_wdata_i;
                        // we_n rises on the last cycle so address/data hold across the edge.
                        ram_we_n_o  = last;
                    end else begin
                        ram_oe_n_o = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rdata_o = mem_rdata_q;

endmodule
